opcode_sweeper: RTL and testbench

OPCODE_SWEEPER -- requirements
Module: opcode_sweeper

---
 rtl/opcode_sweeper.sv | 128 ++++++++++++
 tb/tb_opcode_sweeper.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_sweeper.sv
// Opcode sweeper: drives every opcode 0..LAST to a decoder, waits SETTLE cycles, and records
// the 1-bit response in mask/count. Optional SWEEP_CHECK_EN adds exp_mask compare -> mismatch.
module opcode_sweeper #(
   parameter int SETTLE = 1,
   parameter int LAST   = 63
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [5:0]  a_out,
   input  logic        b_in,
   output logic        busy,
   output logic        done,
   output logic [63:0] mask,
   output logic [6:0]  count
`ifdef SWEEP_CHECK_EN
   ,
   input  logic [63:0] exp_mask,
   output logic        mismatch
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [5:0]  LAST_OP   = 6'(LAST);
   localparam logic [6:0]  COUNT_MAX = 7'(LAST + 1);
   localparam logic [3:0]  SETTLE_LD = 4'(SETTLE);

   state_t      state, state_nxt;
   logic [5:0]  a_out_nxt;
   logic        busy_nxt;
   logic        done_nxt;
   logic [63:0] mask_nxt;
   logic [6:0]  count_nxt;
   logic [3:0]  settle, settle_nxt;

`ifdef SWEEP_CHECK_EN
   localparam logic [63:0] VALID_BITS = (64'd1 << (LAST + 1)) - 64'd1;
   logic mismatch_nxt;
`endif

   // Saturating increment keeps count bounded at LAST+1 even if the FSM were ever re-entered.
   function automatic logic [6:0] sat_inc(input logic [6:0] value);
      sat_inc = (value < COUNT_MAX) ? value + 7'd1 : value;
   endfunction

   always_comb begin
      state_nxt  = state;
      a_out_nxt  = a_out;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      mask_nxt   = mask;
      count_nxt  = count;
      settle_nxt = settle;
`ifdef SWEEP_CHECK_EN
      mismatch_nxt = mismatch;
`endif
      case (state)
         IDLE, DONE: begin
            state_nxt = IDLE;
            if (start) begin
               state_nxt  = RUN;
               a_out_nxt  = 6'd0;
               busy_nxt   = 1'b1;
               mask_nxt   = 64'd0;
               count_nxt  = 7'd0;
               settle_nxt = SETTLE_LD;
`ifdef SWEEP_CHECK_EN
               mismatch_nxt = 1'b0;
`endif
            end
         end
         RUN: begin
            // settle==1 marks the SETTLE-th edge since a_out last changed.
            if (settle == 4'd1) begin
               mask_nxt[a_out] = b_in;
               if (b_in) count_nxt = sat_inc(count);
               if (a_out == LAST_OP) begin
                  state_nxt  = DONE;
                  busy_nxt   = 1'b0;
                  done_nxt   = 1'b1;
                  settle_nxt = 4'd0;
`ifdef SWEEP_CHECK_EN
                  mismatch_nxt = |((mask_nxt ^ exp_mask) & VALID_BITS);
`endif
               end else begin
                  a_out_nxt  = a_out + 6'd1;
                  settle_nxt = SETTLE_LD;
               end
            end else begin
               settle_nxt = settle - 4'd1;
            end
         end
         default: begin
            state_nxt  = IDLE;
            busy_nxt   = 1'b0;
            settle_nxt = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         a_out  <= 6'd0;
         busy   <= 1'b0;
         done   <= 1'b0;
         mask   <= 64'd0;
         count  <= 7'd0;
         settle <= 4'd0;
`ifdef SWEEP_CHECK_EN
         mismatch <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         a_out  <= a_out_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         mask   <= mask_nxt;
         count  <= count_nxt;
         settle <= settle_nxt;
`ifdef SWEEP_CHECK_EN
         mismatch <= mismatch_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_opcode_sweeper.sv
// Bench for opcode_sweeper: two instances (SETTLE=1/LAST=63 and SETTLE=3/LAST=7) driven from a
// vector table plus hand-written abort and back-to-back sequences; expected results via a queue.
module tb_opcode_sweeper;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start [2];
   logic [5:0]  a [2];
   logic        b [2];
   logic        busy [2];
   logic        done [2];
   logic [63:0] mask [2];
   logic [6:0]  count [2];
   logic [63:0] pat [2];
`ifdef SWEEP_CHECK_EN
   logic [63:0] xm [2];
   logic        mm [2];
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] m;
      int          c;
   } exp_t;
   exp_t sbq [$];

   typedef struct {
      int          d;
      logic [63:0] p;
      bit          hold;
      logic [63:0] em;
      int          ec;
   } vec_t;
   vec_t tbl [6];

   always #5 clk = ~clk;

   assign b[0] = pat[0][a[0]];
   assign b[1] = pat[1][a[1]];

   opcode_sweeper #(.SETTLE(1), .LAST(63)) u0 (
      .clk(clk), .reset(reset), .start(start[0]), .a_out(a[0]), .b_in(b[0]),
      .busy(busy[0]), .done(done[0]), .mask(mask[0]), .count(count[0])
`ifdef SWEEP_CHECK_EN
      , .exp_mask(xm[0]), .mismatch(mm[0])
`endif
   );

   opcode_sweeper #(.SETTLE(3), .LAST(7)) u1 (
      .clk(clk), .reset(reset), .start(start[1]), .a_out(a[1]), .b_in(b[1]),
      .busy(busy[1]), .done(done[1]), .mask(mask[1]), .count(count[1])
`ifdef SWEEP_CHECK_EN
      , .exp_mask(xm[1]), .mismatch(mm[1])
`endif
   );

   function automatic int s_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int l_of(input int d);
      return (d == 0) ? 63 : 7;
   endfunction

   function automatic logic [63:0] vmask(input int l);
      logic [63:0] one;
      one = 64'd1;
      return (l >= 63) ? ~64'd0 : ((one << (l + 1)) - 64'd1);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // One full sweep on instance d; chain re-asserts start in the done cycle and returns there.
   task automatic run(input int d, input logic [63:0] p, input bit hold, input bit chain,
                      input bit skip, input logic [63:0] em, input int ec);
      int   s, l, total, exp_a;
      bit   got;
      exp_t e;
      s = s_of(d);
      l = l_of(d);
      total = (l + 1) * s;
      pat[d] = p;
      if (!skip) begin
         @(negedge clk);
         start[d] = 1'b1;
      end
      @(posedge clk);
      e.m = em;
      e.c = ec;
      sbq.push_back(e);
      got = 0;
      for (int n = 0; n <= total + 3; n++) begin
         @(negedge clk);
         if (!hold && n == 0) start[d] = 1'b0;
         if (hold && n == total - 1) start[d] = 1'b0;
         if (n == 0) begin
            chk("mask_clear", mask[d], 64'd0);
            chk("count_clear", 64'(count[d]), 64'd0);
`ifdef SWEEP_CHECK_EN
            chk("mismatch_clear", 64'(mm[d]), 64'd0);
`endif
         end
         exp_a = (n / s > l) ? l : n / s;
         chk("a_out", 64'(a[d]), 64'(exp_a));
         chk("busy", 64'(busy[d]), 64'(n < total));
         chk("done", 64'(done[d]), 64'(n == total));
         if (done[d] && !got && sbq.size() > 0) begin
            got = 1;
            e = sbq.pop_front();
            chk("mask", mask[d], e.m);
            chk("count", 64'(count[d]), 64'(e.c));
`ifdef SWEEP_CHECK_EN
            chk("mismatch", 64'(mm[d]), 64'(|((e.m ^ xm[d]) & vmask(l))));
`endif
         end
         if (n == total && chain) begin
            start[d] = 1'b1;
            break;
         end
         if (n == total + 3) begin
            chk("mask_hold", mask[d], em);
            chk("count_hold", 64'(count[d]), 64'(ec));
         end
      end
      chk("done_seen", 64'(got), 64'd1);
      if (!got && sbq.size() > 0) void'(sbq.pop_front());
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      start[0] = 1'b0;
      start[1] = 1'b0;
      pat[0] = 64'd0;
      pat[1] = 64'd0;
`ifdef SWEEP_CHECK_EN
      xm[0] = 64'd0;
      xm[1] = 64'd0;
`endif
      tbl[0] = '{0, 64'h0000_0008_0000_0000, 1'b0, 64'h0000_0008_0000_0000, 1};
      tbl[1] = '{0, ~64'd0, 1'b1, ~64'd0, 64};
      tbl[2] = '{0, 64'd0, 1'b0, 64'd0, 0};
      tbl[3] = '{1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'h0000_0000_0000_00AA, 4};
      tbl[4] = '{1, 64'hFFFF_FFFF_FFFF_FF5A, 1'b1, 64'h0000_0000_0000_005A, 4};
      tbl[5] = '{0, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'hDEAD_BEEF_0123_4567,
                 $countones(64'hDEAD_BEEF_0123_4567)};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_a_out", 64'(a[d]), 64'd0);
         chk("rst_busy", 64'(busy[d]), 64'd0);
         chk("rst_done", 64'(done[d]), 64'd0);
         chk("rst_mask", mask[d], 64'd0);
         chk("rst_count", 64'(count[d]), 64'd0);
`ifdef SWEEP_CHECK_EN
         chk("rst_mismatch", 64'(mm[d]), 64'd0);
`endif
      end
      reset = 1'b1;

      // Abort mid-sweep: reset wins over start and suppresses done
      pat[0] = ~64'd0;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[0] = 1'b0;
      repeat (19) @(negedge clk);
      chk("pre_abort_mask", mask[0], 64'h0000_0000_0007_FFFF);
      chk("pre_abort_count", 64'(count[0]), 64'd19);
      reset = 1'b0;
      start[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_a_out", 64'(a[0]), 64'd0);
      chk("abort_busy", 64'(busy[0]), 64'd0);
      chk("abort_done", 64'(done[0]), 64'd0);
      chk("abort_mask", mask[0], 64'd0);
      chk("abort_count", 64'(count[0]), 64'd0);
      reset = 1'b1;
      start[0] = 1'b0;
      dones = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done[0]) dones++;
      end
      chk("abort_no_done", 64'(dones), 64'd0);
      chk("abort_idle_busy", 64'(busy[0]), 64'd0);

      for (int i = 0; i < 6; i++)
         run(tbl[i].d, tbl[i].p, tbl[i].hold, 1'b0, 1'b0, tbl[i].em, tbl[i].ec);

      // Start accepted in the done cycle of the previous sweep
      run(1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_00AA, 4);
      run(1, ~64'd0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_00FF, 8);

`ifdef SWEEP_CHECK_EN
      xm[1] = 64'h0000_0000_0000_00FF;
      run(1, ~64'd0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_00FF, 8);
      chk("mismatch_zero", 64'(mm[1]), 64'd0);
      xm[1] = 64'h0000_0000_0000_00F7;
      run(1, ~64'd0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_00FF, 8);
      chk("mismatch_one", 64'(mm[1]), 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
